// File: rtl/wave_copy_sequencer.sv
// ---------------------------------------------------------------------------
// wave_copy_sequencer
//
// Copies a block of samples from main memory into up to NUM_DEST destination
// BRAM write ports. Requesters are served round-robin. The granted requester's
// source base, sample count and destination mask are captured at grant time.
// Reads are issued one per cycle. The read index travels alongside the
// main-memory read latency, so each returning sample is written to the same
// index in every selected destination.
//
// Ports
//   clk_in, rst_in      clock (rising edge) and asynchronous active-high reset
//   req_in              level copy requests, held until granted
//   src_base_in         per-requester main-memory base address
//   width_in            per-requester sample count (0 = empty copy)
//   dest_mask_in        per-requester destination select
//   abort_in            terminates the active copy
//   grant_out           one-hot grant pulse, one cycle
//   busy_out            high whenever not idle
//   done_out            one-cycle completion pulse
//   aborted_out         qualifies done_out when the copy was aborted
//   mmem_addr_out/_en   main-memory read port
//   mmem_data_in        main-memory read data, READ_LATENCY cycles after en
//   wr_addr_out         destination write address, shared by all destinations
//   wr_data_out         destination write data (mmem_data_in passed through)
//   wr_en_out           per-destination write enable
//   checksum_out        sum of samples written by the current/last copy
//
// Build option
//   WAVE_COPY_CHECKSUM_EN  when defined, builds the checksum accumulator;
//                          otherwise checksum_out is tied to zero.
// ---------------------------------------------------------------------------
module wave_copy_sequencer #(
  parameter int NUM_REQ         = 2,
  parameter int NUM_DEST        = 6,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 18,
  parameter int MMEM_ADDR_WIDTH = 18,
  parameter int READ_LATENCY    = 2
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic [NUM_REQ-1:0]                          req_in,
  input  logic [NUM_REQ-1:0][MMEM_ADDR_WIDTH-1:0]     src_base_in,
  input  logic [NUM_REQ-1:0][WW_WIDTH-1:0]            width_in,
  input  logic [NUM_REQ-1:0][NUM_DEST-1:0]            dest_mask_in,
  input  logic                                        abort_in,
  output logic [NUM_REQ-1:0]                          grant_out,
  output logic                                        busy_out,
  output logic                                        done_out,
  output logic                                        aborted_out,
  output logic [MMEM_ADDR_WIDTH-1:0]                  mmem_addr_out,
  output logic                                        mmem_en_out,
  input  logic [SAMPLE_WIDTH-1:0]                     mmem_data_in,
  output logic [WW_WIDTH-1:0]                         wr_addr_out,
  output logic [SAMPLE_WIDTH-1:0]                     wr_data_out,
  output logic [NUM_DEST-1:0]                         wr_en_out,
  output logic [SAMPLE_WIDTH+WW_WIDTH-1:0]            checksum_out
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = SAMPLE_WIDTH + WW_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                       state_q;
  state_t                       state_d;

  logic [RW-1:0]                rr_ptr_q;
  logic [RW-1:0]                gnt_idx;
  logic [RW-1:0]                next_ptr;
  logic                         gnt_found;
  logic [RW:0]                  cand;
  logic [RW:0]                  ptr_inc;

  logic                         grant_fire;
  logic                         abort_fire;
  logic                         last_rd;
  logic                         drain_last;

  logic [MMEM_ADDR_WIDTH-1:0]   base_q;
  logic [WW_WIDTH-1:0]          width_q;
  logic [NUM_DEST-1:0]          mask_q;
  logic [WW_WIDTH-1:0]          idx_q;
  logic [2:0]                   drain_cnt_q;
  logic                         aborted_q;
  logic [NUM_REQ-1:0]           grant_q;

  logic                         vld_p [READ_LATENCY];
  logic [WW_WIDTH-1:0]          idx_p [READ_LATENCY];
  logic                         wr_vld;

  // Round-robin pick: scan upward from the pointer, wrapping at NUM_REQ.
  // One extra bit on the candidate keeps the wrap test exact for any NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (RW+1)'(i);
      if (cand >= (RW+1)'(NUM_REQ)) begin
        cand = cand - (RW+1)'(NUM_REQ);
      end
      if (!gnt_found && req_in[cand[RW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[RW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, gnt_idx} + (RW+1)'(1);
    if (ptr_inc >= (RW+1)'(NUM_REQ)) begin
      ptr_inc = '0;
    end
    next_ptr = ptr_inc[RW-1:0];
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    grant_fire = (state_q == ST_IDLE) && gnt_found;
    abort_fire = ((state_q == ST_READ) || (state_q == ST_DRAIN)) && abort_in;
    last_rd    = (idx_q == (width_q - WW_WIDTH'(1)));
    drain_last = (drain_cnt_q == 3'(READ_LATENCY - 1));
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          state_d = (width_in[gnt_idx] == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (abort_in) begin
          state_d = ST_DONE;
        end else if (last_rd) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort_in || drain_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control registers: pointer, read index, drain counter, abort flag, grant
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      drain_cnt_q <= '0;
      aborted_q   <= 1'b0;
      grant_q     <= '0;
    end else begin
      grant_q <= '0;
      if (grant_fire) begin
        grant_q     <= NUM_REQ'(1) << gnt_idx;
        rr_ptr_q    <= next_ptr;
        idx_q       <= '0;
        drain_cnt_q <= '0;
        aborted_q   <= 1'b0;
      end
      if (state_q == ST_READ) begin
        idx_q <= idx_q + WW_WIDTH'(1);
      end
      if (state_q == ST_DRAIN) begin
        drain_cnt_q <= drain_cnt_q + 3'd1;
      end
      if (abort_fire) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Copy descriptor, captured once per grant and held while busy
  always_ff @(posedge clk_in) begin
    if (grant_fire) begin
      base_q  <= src_base_in[gnt_idx];
      width_q <= width_in[gnt_idx];
      mask_q  <= dest_mask_in[gnt_idx];
    end
  end

  // Read-latency pipeline, p0 = issue edge; valid is flushed on abort so no
  // write emerges after the copy has been terminated.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else if (abort_fire) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0] <= (state_q == ST_READ);
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    idx_p[0] <= idx_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      idx_p[i] <= idx_p[i-1];
    end
  end

  // Output stage: write strobes align with the returning read data
  assign wr_vld        = vld_p[READ_LATENCY-1];
  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = (state_q == ST_DONE);
  assign aborted_out   = done_out && aborted_q;
  assign grant_out     = grant_q;
  assign mmem_en_out   = (state_q == ST_READ);
  assign mmem_addr_out = mmem_en_out ? (base_q + MMEM_ADDR_WIDTH'(idx_q)) : '0;
  assign wr_en_out     = wr_vld ? mask_q : '0;
  assign wr_addr_out   = wr_vld ? idx_p[READ_LATENCY-1] : '0;
  assign wr_data_out   = wr_vld ? mmem_data_in : '0;

`ifdef WAVE_COPY_CHECKSUM_EN
  logic [CW-1:0] csum_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      csum_q <= '0;
    end else if (grant_fire) begin
      csum_q <= '0;
    end else if (wr_vld && (|mask_q)) begin
      csum_q <= csum_q + CW'(mmem_data_in);
    end
  end

  assign checksum_out = csum_q;
`else
  assign checksum_out = '0;
`endif

endmodule

// File: tb/tb_wave_copy_sequencer.sv
module tb_wave_copy_sequencer;

  localparam int NR  = 2;
  localparam int ND  = 6;
  localparam int SW  = 16;
  localparam int WW  = 18;
  localparam int AW  = 18;
  localparam int LAT = 2;
  localparam int CW  = SW + WW;
  localparam int RB  = 1;

`ifdef WAVE_COPY_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic                      clk_in = 1'b0;
  logic                      rst_in = 1'b1;
  logic [NR-1:0]             req_in;
  logic [NR-1:0][AW-1:0]     src_base_in;
  logic [NR-1:0][WW-1:0]     width_in;
  logic [NR-1:0][ND-1:0]     dest_mask_in;
  logic                      abort_in;
  logic [NR-1:0]             grant_out;
  logic                      busy_out;
  logic                      done_out;
  logic                      aborted_out;
  logic [AW-1:0]             mmem_addr_out;
  logic                      mmem_en_out;
  logic [SW-1:0]             mmem_data_in;
  logic [WW-1:0]             wr_addr_out;
  logic [SW-1:0]             wr_data_out;
  logic [ND-1:0]             wr_en_out;
  logic [CW-1:0]             checksum_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  wave_copy_sequencer #(
    .NUM_REQ(NR), .NUM_DEST(ND), .SAMPLE_WIDTH(SW), .WW_WIDTH(WW),
    .MMEM_ADDR_WIDTH(AW), .READ_LATENCY(LAT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in),
    .src_base_in(src_base_in), .width_in(width_in), .dest_mask_in(dest_mask_in),
    .abort_in(abort_in), .grant_out(grant_out), .busy_out(busy_out),
    .done_out(done_out), .aborted_out(aborted_out),
    .mmem_addr_out(mmem_addr_out), .mmem_en_out(mmem_en_out),
    .mmem_data_in(mmem_data_in), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .wr_en_out(wr_en_out), .checksum_out(checksum_out)
  );

  // Main memory: content is address plus an offset, returned LAT cycles later
  logic [SW-1:0] data_off;
  logic [SW-1:0] mem_pipe [LAT];

  function automatic logic [SW-1:0] mdata(input logic [AW-1:0] a, input logic [SW-1:0] off);
    return SW'(a) + off;
  endfunction

  always @(posedge clk_in) begin
    mem_pipe[0] <= mdata(mmem_addr_out, data_off);
    for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mmem_data_in = mem_pipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a copy is described by its start (grant) and the
  // cycle offset t since then; every output is a function of t.
  bit              m_busy = 1'b0;
  int              m_t, m_end, m_k, m_w;
  int              m_last = NR - 1;
  logic [AW-1:0]   m_base;
  logic [ND-1:0]   m_mask;
  logic [SW-1:0]   m_off;
  bit              m_ab;
  logic [CW-1:0]   m_sum = '0;

  // observations for literal checks
  int              obs_busy, obs_wr, obs_done, obs_ab;
  logic [ND-1:0]   obs_wen_or;
  logic [AW-1:0]   obs_addr [$];
  logic [WW-1:0]   obs_waddr [$];
  logic [NR-1:0]   obs_gnt [$];

  task automatic clear_obs();
    obs_busy = 0; obs_wr = 0; obs_done = 0; obs_ab = 0; obs_wen_or = '0;
    obs_addr.delete(); obs_waddr.delete(); obs_gnt.delete();
  endtask

  function automatic bit m_writes(input int t);
    return (t >= LAT) && (t - LAT < m_w) && (t < m_end);
  endfunction

  initial begin
    logic          e_busy, e_done, e_ab, e_en;
    logic [NR-1:0] e_gnt;
    logic [AW-1:0] e_addr;
    logic [ND-1:0] e_wen;
    logic [WW-1:0] e_waddr;
    logic [SW-1:0] e_wdata;
    logic [CW-1:0] e_sum;
    int            c, k;
    bit            found;
    forever begin
      @(negedge clk_in);
      e_busy = 0; e_gnt = '0; e_done = 0; e_ab = 0; e_en = 0;
      e_addr = '0; e_wen = '0; e_waddr = '0; e_wdata = '0;
      if (!rst_in && m_busy) begin
        e_busy = 1;
        if (m_t == 0) e_gnt = NR'(1) << m_k;
        if (m_t == m_end) begin e_done = 1; e_ab = m_ab; end
        if (m_t < m_w && m_t < m_end) begin
          e_en = 1; e_addr = m_base + AW'(m_t);
        end
        if (m_writes(m_t)) begin
          e_wen = m_mask; e_waddr = WW'(m_t - LAT);
          e_wdata = mdata(m_base + AW'(m_t - LAT), m_off);
        end
      end
      e_sum = (CHK_EN && !rst_in) ? m_sum : '0;
      chk("busy", busy_out, e_busy);
      chk("grant", grant_out, e_gnt);
      chk("done", done_out, e_done);
      chk("aborted", aborted_out, e_ab);
      chk("mmem_en", mmem_en_out, e_en);
      chk("mmem_addr", mmem_addr_out, e_addr);
      chk("wr_en", wr_en_out, e_wen);
      chk("wr_addr", wr_addr_out, e_waddr);
      chk("wr_data", wr_data_out, e_wdata);
      chk("checksum", checksum_out, e_sum);
      if (busy_out) obs_busy++;
      if (mmem_en_out) obs_addr.push_back(mmem_addr_out);
      if (wr_en_out != '0) begin
        obs_wr++; obs_waddr.push_back(wr_addr_out); obs_wen_or |= wr_en_out;
      end
      if (grant_out != '0) obs_gnt.push_back(grant_out);
      if (done_out) obs_done++;
      if (aborted_out) obs_ab++;
      // advance the model over the coming edge
      if (rst_in) begin
        m_busy = 0; m_last = NR - 1; m_sum = '0; m_ab = 0;
      end else if (!m_busy) begin
        found = 0; k = 0;
        for (int j = 1; j <= NR; j++) begin
          c = (m_last + j) % NR;
          if (!found && req_in[c[RB-1:0]]) begin found = 1; k = c; end
        end
        if (found) begin
          m_busy = 1; m_t = 0; m_k = k; m_last = k;
          m_w = int'(width_in[k[RB-1:0]]);
          m_base = src_base_in[k[RB-1:0]];
          m_mask = dest_mask_in[k[RB-1:0]];
          m_off = data_off; m_sum = '0; m_ab = 0;
          m_end = (m_w == 0) ? 0 : m_w + LAT;
        end
      end else begin
        if (m_writes(m_t) && m_mask != '0)
          m_sum = m_sum + CW'(mdata(m_base + AW'(m_t - LAT), m_off));
        if (m_t == m_end) m_busy = 0;
        else begin
          if (abort_in) begin m_end = m_t + 1; m_ab = 1; end
          m_t++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_out && n < 300) begin tick(); n++; end
    chk("idle_timeout", busy_out, 0);
  endtask

  task automatic do_copy(input int r, input logic [AW-1:0] base, input int w,
                         input logic [ND-1:0] mask, input int abort_at);
    int n;
    src_base_in[r[RB-1:0]]  = base;
    width_in[r[RB-1:0]]     = WW'(w);
    dest_mask_in[r[RB-1:0]] = mask;
    req_in[r[RB-1:0]]       = 1'b1;
    n = 0;
    while (grant_out == '0 && n < 50) begin tick(); n++; end
    chk("grant_seen", grant_out != '0, 1);
    req_in = '0;
    n = 0;
    while (busy_out && n < 300) begin
      abort_in = (n == abort_at);
      tick(); n++;
    end
    abort_in = 1'b0;
    chk("copy_timeout", busy_out, 0);
    tick();
  endtask

  initial begin
    int n, gc;
    req_in = '0; src_base_in = '0; width_in = '0; dest_mask_in = '0;
    abort_in = 1'b0; data_off = '0;
    clear_obs();
    repeat (3) tick();
    chk("rst_busy", busy_out, 0);
    chk("rst_grant", grant_out, 0);
    chk("rst_mmem_en", mmem_en_out, 0);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_checksum", checksum_out, 0);
    #1 rst_in = 1'b0;
    tick();

    // basic copy: 4 samples from 0x100 to destination 0
    clear_obs();
    do_copy(0, 18'h00100, 4, 6'b000001, -1);
    chk("t1_busy_cycles", obs_busy, 7);
    chk("t1_naddr", obs_addr.size(), 4);
    for (int i = 0; i < obs_addr.size() && i < 4; i++)
      chk("t1_addr", obs_addr[i], 18'h00100 + i);
    chk("t1_nwr", obs_wr, 4);
    for (int i = 0; i < obs_waddr.size() && i < 4; i++)
      chk("t1_waddr", obs_waddr[i], i);
    chk("t1_wen", obs_wen_or, 6'b000001);
    chk("t1_done", obs_done, 1);
    chk("t1_aborted", obs_ab, 0);

    // empty copy
    clear_obs();
    do_copy(1, 18'h00200, 0, 6'b000010, -1);
    chk("t2_busy_cycles", obs_busy, 1);
    chk("t2_naddr", obs_addr.size(), 0);
    chk("t2_nwr", obs_wr, 0);
    chk("t2_done", obs_done, 1);
    chk("t2_ngrant", obs_gnt.size(), 1);

    // address wrap
    clear_obs();
    do_copy(0, 18'h3FFFE, 4, 6'b100000, -1);
    chk("t3_naddr", obs_addr.size(), 4);
    if (obs_addr.size() == 4) begin
      chk("t3_addr0", obs_addr[0], 18'h3FFFE);
      chk("t3_addr1", obs_addr[1], 18'h3FFFF);
      chk("t3_addr2", obs_addr[2], 18'h00000);
      chk("t3_addr3", obs_addr[3], 18'h00001);
    end

    // abort on the second READ cycle
    clear_obs();
    do_copy(1, 18'h00040, 8, 6'b001100, 1);
    chk("t4_done", obs_done, 1);
    chk("t4_aborted", obs_ab, 1);
    chk("t4_nwr", obs_wr, 0);
    chk("t4_naddr", obs_addr.size(), 2);
    chk("t4_busy_cycles", obs_busy, 3);

    // checksum over samples 1,2,3,4
    data_off = 16'hFF01;
    clear_obs();
    do_copy(0, 18'h00100, 4, 6'b000011, -1);
    chk("t5_checksum", checksum_out, CHK_EN ? 10 : 0);
    tick();
    chk("t5_checksum_hold", checksum_out, CHK_EN ? 10 : 0);

    // reset in the middle of a copy
    clear_obs();
    src_base_in[0] = 18'h00300; width_in[0] = 18'd8; dest_mask_in[0] = 6'b111111;
    req_in = 2'b01;
    n = 0;
    while (grant_out == '0 && n < 50) begin tick(); n++; end
    req_in = '0;
    repeat (3) tick();
    chk("t6_was_writing", wr_en_out, 6'b111111);
    #1 rst_in = 1'b1;
    #1;
    chk("t6_busy", busy_out, 0);
    chk("t6_grant", grant_out, 0);
    chk("t6_done", done_out, 0);
    chk("t6_aborted", aborted_out, 0);
    chk("t6_mmem_en", mmem_en_out, 0);
    chk("t6_mmem_addr", mmem_addr_out, 0);
    chk("t6_wr_en", wr_en_out, 0);
    chk("t6_wr_addr", wr_addr_out, 0);
    chk("t6_wr_data", wr_data_out, 0);
    chk("t6_checksum", checksum_out, 0);
    repeat (2) tick();
    #1 rst_in = 1'b0;
    repeat (4) tick();
    chk("t6_no_done", obs_done, 0);

    // held requests from both: round robin restarts at requester 0
    clear_obs();
    data_off = 16'h1234;
    src_base_in[0] = 18'h01000; width_in[0] = 18'd2; dest_mask_in[0] = 6'b000100;
    src_base_in[1] = 18'h02000; width_in[1] = 18'd3; dest_mask_in[1] = 6'b010000;
    req_in = 2'b11;
    gc = 0; n = 0;
    while (gc < 3 && n < 100) begin
      tick(); n++;
      if (grant_out != '0) gc++;
      if (gc == 3) req_in = '0;
    end
    req_in = '0;
    wait_idle();
    tick();
    chk("t7_ngrant", obs_gnt.size(), 3);
    if (obs_gnt.size() == 3) begin
      chk("t7_grant0", obs_gnt[0], 2'b01);
      chk("t7_grant1", obs_gnt[1], 2'b10);
      chk("t7_grant2", obs_gnt[2], 2'b01);
    end

    // randomized copies against the model
    for (int it = 0; it < 60; it++) begin
      data_off = SW'($urandom);
      for (int r = 0; r < NR; r++) begin
        src_base_in[r[RB-1:0]]  = AW'($urandom);
        width_in[r[RB-1:0]]     = WW'($urandom_range(0, 12));
        dest_mask_in[r[RB-1:0]] = ND'($urandom_range(1, 63));
      end
      req_in = NR'($urandom_range(1, 3));
      n = 0;
      while ((req_in != '0 || busy_out) && n < 500) begin
        abort_in = ($urandom_range(0, 11) == 0);
        tick(); n++;
        req_in = req_in & ~grant_out;
        if (busy_out) begin
          for (int r = 0; r < NR; r++) begin
            src_base_in[r[RB-1:0]]  = AW'($urandom);
            width_in[r[RB-1:0]]     = WW'($urandom_range(0, 12));
            dest_mask_in[r[RB-1:0]] = ND'($urandom_range(1, 63));
          end
        end
      end
      abort_in = 1'b0;
      chk("rand_timeout", (req_in != '0) || busy_out, 0);
      req_in = '0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
